// File: rtl/operand_issue_ctrl.sv
// operand_issue_ctrl: issues one decoded instruction at a time, reads x1..x31 operands, starts the ALU and writes back.
// Define ISSUE_WATCHDOG_EN to add the EXEC watchdog and the sticky oTIMEOUT output.
module operand_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iISSUE_VALID,
    output logic        oISSUE_READY,
    input  logic [4:0]  iRD,
    input  logic [4:0]  iRS1,
    input  logic [4:0]  iRS2,
    input  logic [31:0] iIMM,
    input  logic        iUSE_IMM,
    input  logic        iWB_EN,
    output logic [31:0] oALU_IN1,
    output logic [31:0] oALU_IN2,
    output logic        oALU_START,
    input  logic [31:0] iALU_OUT,
    input  logic        iALU_DONE,
    output logic        oRETIRE,
    output logic [4:0]  oWB_RD,
    output logic [31:0] oWB_DATA,
`ifdef ISSUE_WATCHDOG_EN
    output logic        oTIMEOUT,
`endif
    input  logic [4:0]  iDBG_ADDR,
    output logic [31:0] oDBG_DATA
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} stateT;
    stateT       state;
    logic [31:0] regs [32];
    logic [4:0]  rdQ, rs1Q, rs2Q;
    logic [31:0] immQ, rs1Val, rs2Val;
    logic        useImmQ, wbEnQ;
`ifdef ISSUE_WATCHDOG_EN
    logic [31:0] wdCnt;
`else
    if (TIMEOUT_CYCLES < 1) begin : gTimeoutMustBePositive
    end
`endif
    assign oISSUE_READY = state == IDLE;
    assign rs1Val = rs1Q == 5'd0 ? 32'd0 : regs[rs1Q];
    assign rs2Val = rs2Q == 5'd0 ? 32'd0 : regs[rs2Q];
    assign oDBG_DATA = iDBG_ADDR == 5'd0 ? 32'd0 : regs[iDBG_ADDR];
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state      <= IDLE;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            rdQ        <= '0;
            rs1Q       <= '0;
            rs2Q       <= '0;
            immQ       <= '0;
            useImmQ    <= 1'b0;
            wbEnQ      <= 1'b0;
            oALU_IN1   <= '0;
            oALU_IN2   <= '0;
            oALU_START <= 1'b0;
            oRETIRE    <= 1'b0;
            oWB_RD     <= '0;
            oWB_DATA   <= '0;
`ifdef ISSUE_WATCHDOG_EN
            wdCnt      <= '0;
            oTIMEOUT   <= 1'b0;
`endif
        end else begin
            oALU_START <= 1'b0;
            oRETIRE    <= 1'b0;
            case (state)
                IDLE: if (iISSUE_VALID) begin
                    rdQ     <= iRD;
                    rs1Q    <= iRS1;
                    rs2Q    <= iRS2;
                    immQ    <= iIMM;
                    useImmQ <= iUSE_IMM;
                    wbEnQ   <= iWB_EN;
                    state   <= READ;
                end
                READ: begin
                    oALU_IN1   <= rs1Val;
                    oALU_IN2   <= useImmQ ? immQ : rs2Val;
                    oALU_START <= 1'b1;
`ifdef ISSUE_WATCHDOG_EN
                    wdCnt      <= '0;
`endif
                    state      <= EXEC;
                end
                EXEC: if (iALU_DONE) begin
                    oWB_DATA <= iALU_OUT;
                    oWB_RD   <= rdQ;
                    oRETIRE  <= 1'b1;
                    state    <= WB;
                end
`ifdef ISSUE_WATCHDOG_EN
                // Give up on a hung unit: retire with a zero result.
                else if (wdCnt == 32'(TIMEOUT_CYCLES - 1)) begin
                    oTIMEOUT <= 1'b1;
                    oWB_DATA <= '0;
                    oWB_RD   <= rdQ;
                    oRETIRE  <= 1'b1;
                    state    <= WB;
                end else wdCnt <= wdCnt + 32'd1;
`endif
                WB: begin
                    if (wbEnQ && rdQ != 5'd0) regs[rdQ] <= oWB_DATA;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
